// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller: default sizes,
// FSM state encoding and the digit-index width helper.
package mult_seq_pkg;

  localparam int DW_DEF = 4;
  localparam int ND_DEF = 2;
  localparam int OW_DEF = DW_DEF * ND_DEF;
  localparam int RW_DEF = 2 * OW_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a digit index; a single-digit operand still needs one bit.
  function automatic int idx_w(input int nd);
    return (nd > 1) ? $clog2(nd) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle between a requester (master) and the
// multiplier sequencer (slave).
interface mult_seq_ctrl_if #(
  parameter int OW = 8,
  parameter int RW = 16
);
  logic          start_valid;
  logic          start_ready;
  logic [OW-1:0] op_a;
  logic [OW-1:0] op_b;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] result;

  modport master (
    output start_valid, op_a, op_b, res_ready,
    input  start_ready, res_valid, result
  );

  modport slave (
    input  start_valid, op_a, op_b, res_ready,
    output start_ready, res_valid, result
  );
endinterface

// File: rtl/mult_seq_acc.sv
// Shift-accumulate register: clears on accept, then adds each partial product
// shifted to its digit position.
module mult_seq_acc
  import mult_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int ND = ND_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add,
  input  logic [2*DW-1:0]         p,
  input  logic [idx_w(ND):0]      pos,
  output logic [2*DW*ND-1:0]      acc
);
  localparam int RW = 2 * DW * ND;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + (RW'(p) << (DW * pos));
    end
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for an 8x8 unsigned multiply on a shared external DWxDW multiplier.
// Optional MULT_SEQ_ZERO_SKIP_EN: a zero operand bypasses CALC straight to DONE.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int ND = ND_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mult_seq_ctrl_if.slave  bus,
  output logic            busy,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  input  logic [2*DW-1:0] mul_p
);
  localparam int OW = DW * ND;
  localparam int RW = 2 * OW;
  localparam int IW = idx_w(ND);

  state_t        state, state_nxt;
  logic [IW-1:0] i_q, j_q;
  logic [OW-1:0] a_q, b_q;
  logic [RW-1:0] acc;
  logic [IW:0]   pos;
  logic          accept, last, zero_op, acc_clr, acc_add;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  assign zero_op = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept = (state == IDLE) && bus.start_valid;
  assign last   = (i_q == IW'(ND - 1)) && (j_q == IW'(ND - 1));
  assign pos    = {1'b0, i_q} + {1'b0, j_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i_q   <= '0;
      j_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= bus.op_a;
        b_q <= bus.op_b;
        i_q <= '0;
        j_q <= '0;
      end else if (state == CALC) begin
        // j is the inner index; both wrap to 0 after the final digit pair.
        if (j_q == IW'(ND - 1)) begin
          j_q <= '0;
          i_q <= last ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    state_nxt       = state;
    bus.start_ready = 1'b0;
    bus.res_valid   = 1'b0;
    mul_a           = '0;
    mul_b           = '0;
    acc_clr         = 1'b0;
    acc_add         = 1'b0;
    unique case (state)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) begin
          acc_clr   = 1'b1;
          state_nxt = zero_op ? DONE : CALC;
        end
      end
      CALC: begin
        mul_a   = a_q[DW*i_q +: DW];
        mul_b   = b_q[DW*j_q +: DW];
        acc_add = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.result = (state == DONE) ? acc : '0;
  assign busy       = (state != IDLE);

  mult_seq_acc #(.DW(DW), .ND(ND)) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .add (acc_add),
    .p   (mul_p),
    .pos (pos),
    .acc (acc)
  );
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl; the shared 4x4 multiplier is modelled here
// as a plain combinational product.
module tb_mult_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_p;
  int         passed = 0;
  int         total  = 0;

  mult_seq_ctrl_if #(.OW(8), .RW(16)) bus ();

  mult_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p)
  );

  assign mul_p = mul_a * mul_b;

  always #5 clk = ~clk;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 4;
`endif

  // Present operands for one edge, then scramble them to prove they were latched.
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    bus.start_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.op_a = 8'hA5;
    bus.op_b = 8'h5A;
  endtask

  // Edges after the accept edge until res_valid is seen (capped at 20).
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.start_ready !== 1'b1) $display("FAIL rst_start_ready: got %b want 1", bus.start_ready); else passed++;
    total++; if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); else passed++;
    total++; if (bus.result !== 16'h0000) $display("FAIL rst_result: got %h want 0000", bus.result); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if ({mul_a, mul_b} !== 8'h00) $display("FAIL rst_mul: got %h want 00", {mul_a, mul_b}); else passed++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (bus.start_ready !== 1'b1) $display("FAIL post_rst_start_ready: got %b want 1", bus.start_ready); else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] exp_mul [4];
    int n;
    exp_mul = '{8'h24, 8'h20, 8'h04, 8'h00};
    accept(8'h02, 8'h04);
    for (int k = 0; k < 4; k++) begin
      total++; if ({mul_a, mul_b} !== exp_mul[k]) $display("FAIL basic_mul%0d: got %h want %h", k, {mul_a, mul_b}, exp_mul[k]); else passed++;
      if (k < 3) begin @(posedge clk); #1; end
    end
    total++; if (bus.res_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", bus.res_valid); else passed++;
    wait_valid(n);
    total++; if (n !== 1) $display("FAIL basic_latency: got %0d more edges want 1", n); else passed++;
    total++; if (bus.result !== 16'h0008) $display("FAIL basic_result: got %h want 0008", bus.result); else passed++;
    total++; if ({mul_a, mul_b} !== 8'h00) $display("FAIL basic_mul_done: got %h want 00", {mul_a, mul_b}); else passed++;
    release_result();
    total++; if (bus.res_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", bus.res_valid); else passed++;
    total++; if (bus.result !== 16'h0000) $display("FAIL basic_result_idle: got %h want 0000", bus.result); else passed++;
  endtask

  task automatic test_max();
    int busy_cycles = 0;
    logic [15:0] got = 16'hxxxx;
    bus.res_ready = 1'b1;
    accept(8'hFF, 8'hFF);
    while (busy && busy_cycles < 20) begin
      if (bus.res_valid) got = bus.result;
      busy_cycles++;
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b0;
    total++; if (got !== 16'hFE01) $display("FAIL max_result: got %h want fe01", got); else passed++;
    total++; if (busy_cycles !== 5) $display("FAIL max_busy_cycles: got %0d want 5", busy_cycles); else passed++;
    total++; if (bus.start_ready !== 1'b1) $display("FAIL max_idle_ready: got %b want 1", bus.start_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    int bad = 0;
    accept(8'h3A, 8'hC5);
    wait_valid(n);
    total++; if (n !== 4) $display("FAIL bp_latency: got %0d want 4", n); else passed++;
    for (int k = 0; k < 6; k++) begin
      if (bus.result !== 16'h2CA2 || bus.res_valid !== 1'b1 || bus.start_ready !== 1'b0) bad++;
      bus.start_valid = (k == 2);
      bus.op_a = 8'h11;
      bus.op_b = 8'h22;
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;
    total++; if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0 (result %h)", bad, bus.result); else passed++;
    total++; if (bus.result !== 16'h2CA2) $display("FAIL bp_result: got %h want 2ca2", bus.result); else passed++;
    release_result();
    total++; if (busy !== 1'b0) $display("FAIL bp_not_queued: got busy %b want 0", busy); else passed++;
    accept(8'h11, 8'h22);
    wait_valid(n);
    total++; if (bus.result !== 16'h0242) $display("FAIL bp_next_result: got %h want 0242", bus.result); else passed++;
    release_result();
  endtask

  task automatic test_reset_mid();
    int n;
    accept(8'h5A, 8'h3C);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
    total++; if (bus.start_ready !== 1'b1) $display("FAIL midrst_start_ready: got %b want 1", bus.start_ready); else passed++;
    total++; if ({mul_a, mul_b} !== 8'h00) $display("FAIL midrst_mul: got %h want 00", {mul_a, mul_b}); else passed++;
    total++; if ({bus.res_valid, bus.result} !== 17'h0) $display("FAIL midrst_result: got %b/%h want 0/0000", bus.res_valid, bus.result); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    accept(8'h07, 8'h09);
    wait_valid(n);
    total++; if (n !== 4) $display("FAIL midrst_latency: got %0d want 4", n); else passed++;
    total++; if (bus.result !== 16'h003F) $display("FAIL midrst_result2: got %h want 003f", bus.result); else passed++;
    release_result();
  endtask

  task automatic test_zero();
    int n;
    accept(8'h00, 8'h37);
    total++; if (mul_a !== 4'h0) $display("FAIL zero_mul_a: got %h want 0", mul_a); else passed++;
    wait_valid(n);
    total++; if (n !== ZERO_LAT) $display("FAIL zero_latency: got %0d want %0d", n, ZERO_LAT); else passed++;
    total++; if ({bus.res_valid, bus.result} !== {1'b1, 16'h0000}) $display("FAIL zero_result: got %b/%h want 1/0000", bus.res_valid, bus.result); else passed++;
    release_result();
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
